// File: rtl/posit_pkg.sv
// Shared posit helpers for the multiplier issue queue: special-value tests and the
// operand pair type at the default 32-bit posit width.
package posit_pkg;

    localparam int unsigned POSIT_N     = 32;
    localparam int unsigned POSIT_MAX_N = 64;

    typedef struct packed {
        logic [POSIT_N-1:0] a;
        logic [POSIT_N-1:0] b;
    } posit_pair_t;

    // Callers zero-extend their N-bit word to POSIT_MAX_N and pass N.
    function automatic logic is_zero(input logic [POSIT_MAX_N-1:0] x);
        return x == '0;
    endfunction

    // NaR is the sign bit alone: bit n-1 set, every lower bit clear.
    function automatic logic is_nar(input logic [POSIT_MAX_N-1:0] x, input int unsigned n);
        logic hit;
        hit = 1'b1;
        for (int unsigned i = 0; i < POSIT_MAX_N; i++) begin
            if (i + 1 < n) begin
                hit &= ~x[i];
            end else if (i + 1 == n) begin
                hit &= x[i];
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/posit_pair_fifo.sv
// Operand-pair FIFO: DEPTH entries of {a,b}, power-of-two pointers that wrap naturally,
// and an occupancy counter that drives full/empty.
module posit_pair_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     push,
    input  logic [N-1:0]             wr_a,
    input  logic [N-1:0]             wr_b,
    input  logic                     pop,
    output logic [N-1:0]             head_a,
    output logic [N-1:0]             head_b,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } pair_t;

    pair_t              mem_q [DEPTH];
    pair_t              mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               push_ok, pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{a: wr_a, b: wr_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: storage has no reset; an entry is only read once level says it was written, and the top masks the head while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_a = mem_q[rd_ptr_q].a;
    assign head_b = mem_q[rd_ptr_q].b;
    assign level  = level_q;

endmodule

// File: rtl/posit_mul_issue_queue.sv
// Operand staging and result capture around the external combinational posit multiplier;
// zero/NaR operands bypass the multiplier output.
module posit_mul_issue_queue
    import posit_pkg::*;
#(
    parameter int N     = 32,
    parameter int ES    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic [N-1:0]             mul_in1,
    output logic [N-1:0]             mul_in2,
    input  logic [N-1:0]             mul_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_result,
    output logic                     out_special,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("posit_mul_issue_queue: DEPTH must be a power of two and at least 2");
    end
    if (ES >= N - 1 || N > int'(POSIT_MAX_N)) begin : g_bad_width
        $error("posit_mul_issue_queue: unsupported N/ES combination");
    end

    logic           push, pop, full, empty;
    logic [N-1:0]   head_a, head_b;
    logic [N-1:0]   byp_result;
    logic           byp_special;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_result_q, out_result_d;
    logic           out_special_q, out_special_d;

    // A full queue refuses the push even when a pop frees a slot on the same edge.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!out_valid_q || out_ready);

    posit_pair_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nReset (nReset),
        .push   (push),
        .wr_a   (in_a),
        .wr_b   (in_b),
        .pop    (pop),
        .head_a (head_a),
        .head_b (head_b),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    assign mul_in1 = empty ? '0 : head_a;
    assign mul_in2 = empty ? '0 : head_b;

    // NaR dominates zero: NaR x 0 is NaR.
    always_comb begin
        byp_result  = mul_out;
        byp_special = 1'b0;
        if (is_nar(POSIT_MAX_N'(head_a), N) || is_nar(POSIT_MAX_N'(head_b), N)) begin
            byp_result  = NAR_WORD;
            byp_special = 1'b1;
        end else if (is_zero(POSIT_MAX_N'(head_a)) || is_zero(POSIT_MAX_N'(head_b))) begin
            byp_result  = '0;
            byp_special = 1'b1;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_special_d = out_special_q;
        if (pop) begin
            out_valid_d   = 1'b1;
            out_result_d  = byp_result;
            out_special_d = byp_special;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_special_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_special_q <= out_special_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_special = out_special_q;

endmodule
